// File: rtl/vedic_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Vedic multiplier.
package vedic_pkg;

   localparam int LEAF_W = 2;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int x = 1; x < v; x = x << 1) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Capture stage + leaf stage + one stage per combine level + sign stage.
   function automatic int vedic_lat(input int width);
      return clog2(width) + 2;
   endfunction

   // Four width-k sub-products merge into one width-2k product per level.
   function automatic int comb_width(input int k);
      return 2 * k;
   endfunction

endpackage

// File: rtl/vedic_mul_2x2.sv
// Combinational 2x2 Urdhva-Tiryagbhyam leaf: vertical and crosswise products of two 2-bit digits.
module vedic_mul_2x2 (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic [3:0] q
);

   logic w_p0;
   logic w_p1;
   logic w_p2;
   logic w_p3;
   logic w_c1;

   assign w_p0 = a[0] & b[0];
   assign w_p1 = a[1] & b[0];
   assign w_p2 = a[0] & b[1];
   assign w_p3 = a[1] & b[1];
   assign w_c1 = w_p1 & w_p2;

   assign q = {w_p3 & w_c1, w_p3 ^ w_c1, w_p1 ^ w_p2, w_p0};

endmodule

// File: rtl/vedic_mul_pipe.sv
// Pipelined sign-magnitude Vedic multiplier: 2x2 leaves merged recursively, one register per level,
// with valid/ready flow control where every stage freezes while the output is back-pressured.
module vedic_mul_pipe
   import vedic_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 is_signed,
   output logic                 q_valid,
   input  logic                 q_ready,
   output logic [2*WIDTH-1:0]   q
);

   localparam int LAT = vedic_lat(WIDTH);
   localparam int N   = LAT - 2;
   localparam int PW  = comb_width(WIDTH);

   logic             w_adv;
   logic             w_accept;
   logic             w_neg;
   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;
   logic [PW-1:0]    w_p;

   logic [WIDTH-1:0] r_mag_a;
   logic [WIDTH-1:0] r_mag_b;
   // Index 0 is the capture stage, index gi the register of combine level gi.
   logic [N:0]       r_v;
   logic [N:0]       r_n;
   logic             r_qv;
   logic [PW-1:0]    r_q;

   assign w_adv    = !r_qv || q_ready;
   assign in_ready = w_adv && !rst;
   assign w_accept = in_valid && in_ready;

   // -2^(WIDTH-1) negates to itself, which reads correctly as an unsigned magnitude.
   assign w_mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
   assign w_mag_b = (is_signed && b[WIDTH-1]) ? -b : b;
   assign w_neg   = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v  <= '0;
         r_qv <= 1'b0;
         r_q  <= '0;
      end else if (w_adv) begin
         r_v  <= {r_v[N-1:0], w_accept};
         r_qv <= r_v[N];
         r_q  <= r_n[N] ? -w_p : w_p;
      end
   end

   always_ff @(posedge clk) begin
      if (w_adv) begin
         r_mag_a <= w_mag_a;
         r_mag_b <= w_mag_b;
         r_n     <= {r_n[N-1:0], w_neg};
      end
   end

   genvar gi, gj, gk;
   generate
      for (gi = 1; gi <= N; gi++) begin : g_lvl
         localparam int K   = 1 << gi;
         localparam int NB  = WIDTH / K;
         localparam int PWL = comb_width(K);

         logic [NB*NB*PWL-1:0] w_prod;
         logic [NB*NB*PWL-1:0] r_prod;

         if (gi == 1) begin : g_leaf
            for (gj = 0; gj < NB; gj++) begin : g_row
               for (gk = 0; gk < NB; gk++) begin : g_col
                  vedic_mul_2x2 u_leaf (
                     .a (r_mag_a[LEAF_W*gj +: LEAF_W]),
                     .b (r_mag_b[LEAF_W*gk +: LEAF_W]),
                     .q (w_prod[(gj*NB+gk)*PWL +: PWL])
                  );
               end
            end
         end else begin : g_comb
            localparam int H = K / 2;
            for (gj = 0; gj < NB; gj++) begin : g_row
               for (gk = 0; gk < NB; gk++) begin : g_col
                  logic [K-1:0] w_hh;
                  logic [K-1:0] w_hl;
                  logic [K-1:0] w_lh;
                  logic [K-1:0] w_ll;
                  logic [K:0]   w_mid;

                  // Previous level is a (2*NB)x(2*NB) grid of K-bit products, row = a block.
                  assign w_hh = g_lvl[gi-1].r_prod[((2*gj+1)*2*NB + 2*gk+1)*K +: K];
                  assign w_hl = g_lvl[gi-1].r_prod[((2*gj+1)*2*NB + 2*gk  )*K +: K];
                  assign w_lh = g_lvl[gi-1].r_prod[((2*gj  )*2*NB + 2*gk+1)*K +: K];
                  assign w_ll = g_lvl[gi-1].r_prod[((2*gj  )*2*NB + 2*gk  )*K +: K];

                  assign w_mid = {1'b0, w_hl} + {1'b0, w_lh};

                  assign w_prod[(gj*NB+gk)*PWL +: PWL] =
                        {w_hh, {K{1'b0}}}
                      + {{(H-1){1'b0}}, w_mid, {H{1'b0}}}
                      + {{K{1'b0}}, w_ll};
               end
            end
         end

         always_ff @(posedge clk) begin
            if (w_adv) begin
               r_prod <= w_prod;
            end
         end
      end
   endgenerate

   assign w_p     = g_lvl[N].r_prod;
   assign q_valid = r_qv;
   assign q       = r_q;

endmodule

// File: doc/vedic_mul_pipe.md
# vedic_mul_pipe

Parametrised, pipelined Urdhva-Tiryagbhyam (Vedic) multiplier: successor to the combinational 2-bit multiplier, generalised to any power-of-two WIDTH. Builds an NxN product recursively from 2x2 Vedic leaves, with one register level per recursion level. Adds a per-transaction signed/unsigned mode and valid/ready flow control with backpressure. Sits in the arithmetic datapath between operand sources and accumulator/MAC consumers. Sustains one product per cycle.

## Interface
- WIDTH, default 8: operand width; power of two, 2..32.
- LAT, derived as log2(WIDTH)+2 and not overridable: pipeline latency in cycles.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair is valid this cycle.
- in_ready  output  1  block accepts the operand pair this cycle.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- is_signed  input  1  1 means a and b are two's complement; 0 means unsigned.
- q_valid  output  1  q holds a valid product.
- q_ready  input  1  downstream accepts q this cycle.
- q  output  2*WIDTH  product; two's complement when the transaction's is_signed=1.

## Operation
- Accept on in_valid && in_ready. Emit on q_valid && q_ready.
- Stage S0 (capture):
  - Register |a| and |b| as WIDTH-bit magnitudes.
  - Register neg = is_signed & (a[MSB] ^ b[MSB]).
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits in WIDTH bits unsigned.
- Stage S1 (leaf): split the magnitudes into 2-bit digits and form every 2x2 partial product with the leaf multiplier. Leaf outputs are 4 bits.
- Stages S2..S(n), with n = log2(WIDTH):
  - Each stage combines four width-k sub-products (hh, hl, lh, ll) into one width-2k product: (hh<<k) + ((hl+lh)<<(k/2)) + ll.
  - Sum is computed at full width; no truncation.
- Final stage: q = neg ? -P : P, computed at 2*WIDTH bits.
  - The unsigned product never exceeds 2^(2*WIDTH-2) in signed mode, so the negation cannot overflow.
- neg and the valid bit travel alongside the data in every stage.
- Pipeline advance: adv = !q_valid || q_ready.
  - All stages shift when adv=1.
  - All stages hold, with data and valid bits frozen, when adv=0.
- in_ready = adv && !rst.
- Bubbles (in_valid=0) propagate as valid=0 slots and are not compressed.

## Timing
- Reset values: q_valid=0, q=0, all internal valid bits 0. in_ready is 0 while rst=1 and 1 on the first cycle after rst deasserts.
- Latency: an operand accepted at edge t appears with q_valid=1 after edge t+LAT-1, provided no stall occurs. This gives a latency of 3 for WIDTH=2 and 5 for WIDTH=8.
- Throughput: one accept per cycle while q_ready=1.
- Stall: while q_valid && !q_ready, q and q_valid stay stable, in_ready=0, and no operand is lost or duplicated.
- Simultaneous pop and push with a full pipeline (q_ready=1, in_valid=1): both occur in the same cycle.
- Reset mid-operation: all in-flight transactions are discarded, and q_valid=0 after the reset edge.
- is_signed is sampled only at accept; changing it later has no effect on in-flight results.

## Structure
- Package vedic_pkg holds:
  - function clog2;
  - localparam computing LAT from WIDTH;
  - the combine-stage width rule (k to 2k).
- Sub-module vedic_mul_2x2: the combinational 2x2 leaf, with inputs a[1:0], b[1:0] and output q[3:0].
  - Instantiated WIDTH²/4 times via generate.
  - Combine levels are generate loops inside vedic_mul_pipe.

## Test plan
- Exhaustive WIDTH=2, unsigned, continuous streaming with q_ready=1: all 16 pairs. Products equal a*b, e.g. 3*3 -> q=4'b1001, each LAT=3 cycles after accept.
- WIDTH=8 signed corners:
  - -128*-128 -> q=16384;
  - -128*127 -> q=-16256 (0xC080);
  - -1*1 -> q=0xFFFF.
- WIDTH=8 unsigned: 255*255 -> q=65025 (0xFE01).
- Backpressure, WIDTH=8: stream 0..9 as a=b. Drop q_ready for 4 cycles mid-stream. Outputs are exactly 0,1,4,…,81 in order, q is held during the stall, and in_ready=0 during the stall.
- Mixed mode back-to-back: (0xFF,0x02,signed) then (0xFF,0x02,unsigned) -> q=0xFFFE, then q=0x01FE.
- Reset with 3 transactions in flight: q_valid=0 on the next cycle, and no stale output appears afterwards. The first post-reset accept of 5*6 yields 30 after LAT cycles.
